// File: rtl/jt49_cengen.sv
// Clock-enable generator for JT49-style PSG cores: optional N/M fractional base
// tick, then power-of-two taps for the tone (cen16) and envelope (cen256) rates.
module jt49_cengen #(
    parameter int unsigned W      = 10,
    parameter int unsigned FW     = 8,
    parameter int unsigned TAP_LO = 3,
    parameter int unsigned TAP_HI = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          sel,
    input  logic          frac_en,
    input  logic          ld,
    input  logic [FW-1:0] num,
    input  logic [FW-1:0] den,
    output logic          cen_base,
    output logic          cen16,
    output logic          cen256
);

    localparam int unsigned SW = FW + 1;

    logic [FW-1:0] num_q, num_d;
    logic [FW-1:0] den_q, den_d;
    logic [FW-1:0] acc_q, acc_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          cen_base_q, cen16_q, cen256_q;

    logic [FW-1:0] acc_e, num_min;
    logic [SW-1:0] sum;
    logic          tick_c, t16_c, t256_c;

    // A load on this edge is seen immediately, with the accumulator restarted.
    always_comb begin
        num_d   = ld ? num : num_q;
        den_d   = ld ? den : den_q;
        acc_e   = ld ? '0 : acc_q;
        num_min = (num_d > den_d) ? den_d : num_d;
        sum     = SW'(acc_e) + SW'(num_min);
    end

    always_comb begin
        tick_c = 1'b0;
        acc_d  = acc_e;
        if (!frac_en || (den_d == '0)) begin
            tick_c = cen;
        end else if (num_d == '0) begin
            tick_c = 1'b0;
        end else if (cen) begin
            if (sum >= SW'(den_d)) begin
                tick_c = 1'b1;
                acc_d  = FW'(sum - SW'(den_d));
            end else begin
                acc_d  = FW'(sum);
            end
        end
    end

    // Taps look at the count before this tick's increment.
    always_comb begin
        cnt_d  = tick_c ? cnt_q + W'(1) : cnt_q;
        t16_c  = sel ? (cnt_q[TAP_LO-1:0] == '0) : (cnt_q[TAP_LO:0] == '0);
        t256_c = sel ? (cnt_q[TAP_HI-1:0] == '0) : (cnt_q[TAP_HI:0] == '0);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q      <= FW'(1);
            den_q      <= FW'(1);
            acc_q      <= '0;
            cnt_q      <= '0;
            cen_base_q <= 1'b0;
            cen16_q    <= 1'b0;
            cen256_q   <= 1'b0;
        end else begin
            num_q      <= num_d;
            den_q      <= den_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            cen_base_q <= tick_c;
            cen16_q    <= tick_c & t16_c;
            cen256_q   <= tick_c & t256_c;
        end
    end

    assign cen_base = cen_base_q;
    assign cen16    = cen16_q;
    assign cen256   = cen256_q;

endmodule

// File: tb/tb_jt49_cengen.sv
// Directed bench for jt49_cengen: a vector table plus multi-cycle sequences
// covering tap periods, fractional ratios, shadow loads and async reset.
module tb_jt49_cengen;

    logic       clk;
    logic       rst_n;
    logic       cen, sel, frac_en, ld;
    logic [7:0] num, den;
    logic       cen_base, cen16, cen256;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_m    = 0;

    typedef struct {
        logic [3:0] in;   // {cen, sel, frac_en, ld}
        logic [7:0] num;
        logic [7:0] den;
        logic [2:0] exp;  // {cen_base, cen16, cen256}
    } vec_t;

    vec_t tbl[$];

    jt49_cengen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .sel      (sel),
        .frac_en  (frac_en),
        .ld       (ld),
        .num      (num),
        .den      (den),
        .cen_base (cen_base),
        .cen16    (cen16),
        .cen256   (cen256)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Registers move on the falling edge; sample 1 time unit after it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        cen = 1'b0; sel = 1'b1; frac_en = 1'b0; ld = 1'b0; num = 8'd0; den = 8'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        cnt_m = 0;
    endtask

    task automatic add(input logic [3:0] in, input logic [7:0] n, input logic [7:0] d,
                       input logic [2:0] e);
        vec_t v;
        v.in = in; v.num = n; v.den = d; v.exp = e;
        tbl.push_back(v);
    endtask

    // Pass-through run with cen held high; expected taps from a tick counter.
    task automatic run_pass(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            cen = 1'b1; sel = s; frac_en = 1'b0; ld = 1'b0;
            step();
            check("pass_base", int'(cen_base), 1);
            check("pass_cen16", int'(cen16), s ? int'(cnt_m % 8 == 0) : int'(cnt_m % 16 == 0));
            check("pass_cen256", int'(cen256), s ? int'(cnt_m % 128 == 0) : int'(cnt_m % 256 == 0));
            cnt_m = (cnt_m + 1) % 1024;
        end
    endtask

    initial begin
        int nb, n16, n256;

        rst_n = 1'b0;
        do_reset();
        check("reset_base", int'(cen_base), 0);
        check("reset_cen16", int'(cen16), 0);
        check("reset_cen256", int'(cen256), 0);

        // Table continues from reset: cnt=0, shadow 1/1.
        add(4'b1100, 8'd0,  8'd0,  3'b111); // first tick, cnt 0
        add(4'b0100, 8'd0,  8'd0,  3'b000);
        add(4'b1100, 8'd0,  8'd0,  3'b100); // cnt 1
        add(4'b1111, 8'd3,  8'd8,  3'b000); // ld 3/8, acc 3
        add(4'b1110, 8'd0,  8'd0,  3'b000); // acc 6
        add(4'b0110, 8'd0,  8'd0,  3'b000); // no cen, held
        add(4'b1110, 8'd0,  8'd0,  3'b100); // 9 -> tick, acc 1, cnt 2
        add(4'b1110, 8'd0,  8'd0,  3'b000); // acc 4
        add(4'b1100, 8'd0,  8'd0,  3'b100); // frac off, cnt 3
        add(4'b1110, 8'd0,  8'd0,  3'b000); // acc 7
        add(4'b1110, 8'd0,  8'd0,  3'b100); // 10 -> tick, cnt 4
        add(4'b1111, 8'd20, 8'd10, 3'b100); // num>den, cnt 5
        add(4'b1110, 8'd0,  8'd0,  3'b100); // cnt 6
        add(4'b1110, 8'd0,  8'd0,  3'b100); // cnt 7
        add(4'b1110, 8'd0,  8'd0,  3'b110); // cnt 8 -> cen16
        add(4'b1010, 8'd0,  8'd0,  3'b100); // sel=0, cnt 9
        add(4'b0010, 8'd0,  8'd0,  3'b000);
        foreach (tbl[i]) begin
            {cen, sel, frac_en, ld} = tbl[i].in;
            num = tbl[i].num;
            den = tbl[i].den;
            step();
            check($sformatf("vec%0d_base", i), int'(cen_base), int'(tbl[i].exp[2]));
            check($sformatf("vec%0d_cen16", i), int'(cen16), int'(tbl[i].exp[1]));
            check($sformatf("vec%0d_cen256", i), int'(cen256), int'(tbl[i].exp[0]));
        end

        // Steady-state periods, then sel switched mid-run without counter reset.
        do_reset(); run_pass(256, 1'b1);
        do_reset(); run_pass(512, 1'b0);
        do_reset(); run_pass(20, 1'b1); run_pass(40, 1'b0); run_pass(20, 1'b1);

        // 3/8 fraction over 800 cen pulses.
        do_reset();
        frac_en = 1'b1; sel = 1'b1; cen = 1'b1; ld = 1'b1; num = 8'd3; den = 8'd8;
        nb = 0; n16 = 0; n256 = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            ld = 1'b0;
            check("frac_base", int'(cen_base), int'((3 * k) / 8 != (3 * (k - 1)) / 8));
            nb += int'(cen_base); n16 += int'(cen16); n256 += int'(cen256);
        end
        check("frac_ticks", nb, 300);
        check("frac_cen16", n16, 38);
        check("frac_cen256", n256, 3);

        // num=0: never ticks.
        do_reset();
        frac_en = 1'b1; cen = 1'b1; ld = 1'b1; num = 8'd0; den = 8'd5;
        nb = 0;
        for (int k = 0; k < 1000; k++) begin
            step(); ld = 1'b0; nb += int'(cen_base);
        end
        check("num0_ticks", nb, 0);

        // den=0: pass-through.
        do_reset();
        frac_en = 1'b1; cen = 1'b1; ld = 1'b1; num = 8'd3; den = 8'd0;
        nb = 0;
        for (int k = 0; k < 16; k++) begin
            step(); ld = 1'b0; nb += int'(cen_base);
            cen = (k % 3 != 0);
        end
        check("den0_ticks", nb, 11);

        // num>den clamps to one tick per cen.
        do_reset();
        frac_en = 1'b1; cen = 1'b1; ld = 1'b1; num = 8'd20; den = 8'd10;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            step(); ld = 1'b0; nb += int'(cen_base);
        end
        check("clamp_ticks", nb, 20);

        // Reload with cen while acc=5: accumulator restarts at 0.
        do_reset();
        frac_en = 1'b1; cen = 1'b1; ld = 1'b1; num = 8'd3; den = 8'd8;
        for (int k = 0; k < 7; k++) begin
            step(); ld = 1'b0;
        end
        check("preload_base", int'(cen_base), 0);
        ld = 1'b1; num = 8'd1; den = 8'd2;
        for (int k = 1; k <= 6; k++) begin
            step(); ld = 1'b0;
            check($sformatf("reload%0d_base", k), int'(cen_base), int'(k % 2 == 0));
        end

        // Async reset while cen16 is high, released with cen high.
        do_reset();
        run_pass(9, 1'b1);
        check("pre_rst_cen16", int'(cen16), 1);
        rst_n = 1'b0;
        #1;
        check("async_base", int'(cen_base), 0);
        check("async_cen16", int'(cen16), 0);
        check("async_cen256", int'(cen256), 0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_base", int'(cen_base), 1);
        check("post_rst_cen16", int'(cen16), 1);
        check("post_rst_cen256", int'(cen256), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
